countdown_bcd: RTL

COUNTDOWN_BCD -- requirements
Module: countdown_bcd

---
 rtl/countdown_bcd.sv | 107 ++++++++++
 1 files changed

// File: rtl/countdown_bcd.sv
// Loadable multi-digit BCD down-counter with a one-cycle terminal-count pulse.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload from RELOAD at terminal count.

module countdown_bcd_digit (
  input  logic [3:0] din,
  input  logic [3:0] cur,
  input  logic       bin,
  output logic [3:0] ld,
  output logic [3:0] dec
);
  always_comb begin
    ld  = (din > 4'd9) ? 4'd9 : din;
    dec = cur;
    if (bin) dec = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
  end
endmodule

module countdown_bcd #(
  parameter int DIGITS = 2
) (
  input  logic                  CLKT,
  input  logic                  R,
  input  logic                  E,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DATA_IN,
  output logic [4*DIGITS-1:0]   CONTADOR,
  output logic                  REGISTRADOR,
  output logic                  BUSY
);
  localparam int W = 4*DIGITS;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  st_q, st_nxt;
  logic [DIGITS-1:0][3:0]  cnt_q, cnt_nxt, ld_val, dec_val, din;
  logic [DIGITS-1:0]       brw;
  logic                    tc_nxt;

  assign din      = DATA_IN;
  assign CONTADOR = cnt_q;

  // Borrow ripples upward through every digit sitting at zero.
  assign brw[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i > 0) begin : g_brw
      assign brw[i] = brw[i-1] & (cnt_q[i-1] == 4'd0);
    end
    countdown_bcd_digit u_dig (
      .din (din[i]),
      .cur (cnt_q[i]),
      .bin (brw[i]),
      .ld  (ld_val[i]),
      .dec (dec_val[i])
    );
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [W-1:0] reload_q;
  always_ff @(posedge CLKT or negedge R) begin
    if (!R)        reload_q <= '0;
    else if (LOAD) reload_q <= ld_val;
  end
`endif

  always_comb begin
    st_nxt  = st_q;
    cnt_nxt = cnt_q;
    tc_nxt  = 1'b0;
    if (LOAD) begin
      cnt_nxt = ld_val;
      st_nxt  = (ld_val == '0) ? DONE : RUN;
    end else begin
      case (st_q)
        RUN: if (E) begin
          if (cnt_q == ONE) begin
            tc_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            cnt_nxt = reload_q;
`else
            cnt_nxt = '0;
            st_nxt  = DONE;
`endif
          end else begin
            cnt_nxt = dec_val;
          end
        end
        DONE:    cnt_nxt = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLKT or negedge R) begin
    if (!R) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      REGISTRADOR <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      st_q        <= st_nxt;
      cnt_q       <= cnt_nxt;
      REGISTRADOR <= tc_nxt;
      BUSY        <= (st_nxt == RUN);
    end
  end
endmodule
